fill_empty_cells_seq: RTL and testbench

Parametrised sequential tile spawner for the 2048 board datapath. On a start request it scans a board snapshot one cell per clock, visiting cells in a caller-supplied visit order beginning at a random rotation offset, and writes new tiles into the first empty cells it finds. It can place several tiles per request and picks each tile value (2 or 4) from the random input. It reports completion, the number of tiles placed, and a board-full condition. It sits between the move/merge logic and the board register, replacing single-tile, fixed-start filling.

---
 rtl/fill_empty_cells_seq.sv | 181 ++++++++++++++++++
 tb/tb_fill_empty_cells_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fill_empty_cells_seq.sv
// fill_empty_cells_seq: sequential tile spawner for the 2048 board datapath.
// Scans a latched board snapshot one cell per clock in a caller-supplied
// visit order, starting at a random rotation offset, and writes 2/4 tiles
// into the first empty cells until the requested count is placed or every
// position has been examined.
module fill_empty_cells_seq #(
  parameter int         N_CELLS     = 16,
  parameter int         CELL_W      = 5,
  parameter int         IDX_W       = $clog2(N_CELLS),
  parameter int         RAND_W      = 6,
  parameter int         SPAWN_W     = 2,
  parameter logic [3:0] FOUR_THRESH = 4'd2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SPAWN_W-1:0]          spawn_req,
  input  logic [N_CELLS*CELL_W-1:0]   cell_all_in,
  input  logic [N_CELLS*IDX_W-1:0]    order_all,
  input  logic [RAND_W-1:0]           random,
  output logic [N_CELLS*CELL_W-1:0]   cell_all_out,
  output logic                        busy,
  output logic                        calc_done,
  output logic                        full,
  output logic [SPAWN_W-1:0]          placed_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [N_CELLS*CELL_W-1:0]   board_q, board_d;
  logic [N_CELLS*IDX_W-1:0]    order_q, order_d;
  logic [IDX_W-1:0]            offset_q, offset_d;
  logic [IDX_W-1:0]            ptr_q, ptr_d;
  logic [SPAWN_W-1:0]          rem_q, rem_d;
  logic [SPAWN_W-1:0]          placed_q, placed_d;
  logic                        full_q, full_d;

  // Scan-cycle helpers: the visit position wraps by plain IDX_W overflow.
  logic [IDX_W-1:0]            pos_s;
  logic [IDX_W-1:0]            idx_s;
  logic [CELL_W-1:0]           cur_cell_s;
  logic                        hit_s;
  logic [CELL_W-1:0]           tile_s;
  logic [SPAWN_W-1:0]          rem_next_s;
  logic                        last_s;

  // Tile value: exponent 2 (a "4") when the random high nibble is below threshold.
  function automatic logic [CELL_W-1:0] tile_value(input logic [3:0] nib);
    if (nib < FOUR_THRESH) begin
      tile_value = CELL_W'(2);
    end else begin
      tile_value = CELL_W'(1);
    end
  endfunction

  // Decode the cell visited this cycle and whether the scan ends with it.
  always_comb begin
    pos_s      = offset_q + ptr_q;
    idx_s      = order_q[pos_s*IDX_W +: IDX_W];
    cur_cell_s = board_q[idx_s*CELL_W +: CELL_W];
    hit_s      = (cur_cell_s == '0);
    tile_s     = tile_value(random[RAND_W-1 -: 4]);
    rem_next_s = rem_q - SPAWN_W'(hit_s);
    last_s     = (rem_next_s == '0) || (ptr_q == IDX_W'(N_CELLS - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (spawn_req == '0) ? ST_DONE : ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers: working board, latched order and scan counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      board_q  <= '0;
      order_q  <= '0;
      offset_q <= '0;
      ptr_q    <= '0;
      rem_q    <= '0;
      placed_q <= '0;
      full_q   <= 1'b0;
    end else begin
      board_q  <= board_d;
      order_q  <= order_d;
      offset_q <= offset_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      placed_q <= placed_d;
      full_q   <= full_d;
    end
  end

  // Datapath next-state: latch on accept, fill empty cells while scanning.
  always_comb begin
    board_d  = board_q;
    order_d  = order_q;
    offset_d = offset_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    placed_d = placed_q;
    full_d   = full_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          board_d  = cell_all_in;
          order_d  = order_all;
          offset_d = random[IDX_W-1:0];
          ptr_d    = '0;
          rem_d    = spawn_req;
          placed_d = '0;
          full_d   = 1'b0;
        end else begin
          board_d  = board_q;
        end
      end
      ST_SCAN: begin
        if (hit_s) begin
          board_d[idx_s*CELL_W +: CELL_W] = tile_s;
          placed_d = placed_q + SPAWN_W'(1);
        end else begin
          placed_d = placed_q;
        end
        rem_d = rem_next_s;
        ptr_d = ptr_q + IDX_W'(1);
        if (last_s) begin
          full_d = (rem_next_s != '0);
        end else begin
          full_d = full_q;
        end
      end
      ST_DONE: begin
        board_d = board_q;
      end
      default: begin
        board_d = board_q;
      end
    endcase
  end

  // Outputs decode straight from registered state and datapath.
  always_comb begin
    busy         = (state_q == ST_SCAN);
    calc_done    = (state_q == ST_DONE);
    cell_all_out = board_q;
    full         = full_q;
    placed_cnt   = placed_q;
  end

endmodule

// File: tb/tb_fill_empty_cells_seq.sv
// Self-checking bench for fill_empty_cells_seq: directed board scenarios plus
// randomized requests compared against a behavioural spawn model.
module tb_fill_empty_cells_seq;
  localparam int N  = 16;
  localparam int CW = 5;
  localparam int IW = 4;
  localparam int RW = 6;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start;
  logic [SW-1:0]     spawn_req;
  logic [N*CW-1:0]   cell_in;
  logic [N*IW-1:0]   order_in;
  logic [RW-1:0]     rnd;
  logic [N*CW-1:0]   cell_out;
  logic              busy, calc_done, full;
  logic [SW-1:0]     placed;

  fill_empty_cells_seq #(.N_CELLS(N), .CELL_W(CW), .IDX_W(IW), .RAND_W(RW),
                         .SPAWN_W(SW), .FOUR_THRESH(4'd2)) dut (
    .clk(clk), .rst(rst), .start(start), .spawn_req(spawn_req),
    .cell_all_in(cell_in), .order_all(order_in), .random(rnd),
    .cell_all_out(cell_out), .busy(busy), .calc_done(calc_done),
    .full(full), .placed_cnt(placed));

  logic              start64;
  logic [1:0]        spawn64;
  logic [64*6-1:0]   cell_in64, order64, cell_out64;
  logic [5:0]        rnd64;
  logic              busy64, done64, full64;
  logic [1:0]        placed64;

  fill_empty_cells_seq #(.N_CELLS(64), .CELL_W(6), .IDX_W(6), .RAND_W(6),
                         .SPAWN_W(2), .FOUR_THRESH(4'd2)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .spawn_req(spawn64),
    .cell_all_in(cell_in64), .order_all(order64), .random(rnd64),
    .cell_all_out(cell_out64), .busy(busy64), .calc_done(done64),
    .full(full64), .placed_cnt(placed64));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request description and expected outcome.
  logic [CW-1:0] bd [N];
  logic [IW-1:0] od [N];
  logic [RW-1:0] ra [128];
  logic [SW-1:0] sp;
  bit            poke;
  logic [CW-1:0] eb [N];
  int            eplaced, em, last_lat;
  bit            efull;

  // Walk the rotated visit order, dropping tiles into empty cells.
  function automatic void model();
    int off, rem, idx;
    off = int'(ra[0][IW-1:0]);
    for (int i = 0; i < N; i++) eb[i] = bd[i];
    rem = int'(sp);
    eplaced = 0;
    em = 0;
    if (rem != 0) begin
      for (int p = 0; p < N; p++) begin
        idx = int'(od[(off + p) % N]);
        em = p + 1;
        if (eb[idx] == 0) begin
          eb[idx] = (ra[p+1][RW-1 -: 4] < 4'd2) ? 5'd2 : 5'd1;
          eplaced++;
          rem--;
        end
        if (rem == 0) break;
      end
    end
    efull = (rem != 0);
  endfunction

  function automatic logic [127:0] exp_board();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*CW +: CW] = eb[i];
    return v;
  endfunction

  task automatic run(input string tag);
    int cyc;
    model();
    @(negedge clk);
    start = 1'b1;
    spawn_req = sp;
    for (int i = 0; i < N; i++) begin
      cell_in[i*CW +: CW]  = bd[i];
      order_in[i*IW +: IW] = od[i];
    end
    rnd = ra[0];
    @(posedge clk); #1;
    start = 1'b0;
    cell_in = {$urandom, $urandom, $urandom};
    order_in = {$urandom, $urandom};
    spawn_req = SW'($urandom);
    rnd = ra[1];
    cyc = 0;
    if (em > 0) check({tag, "/busy_hi"}, 128'(busy), 128'(1));
    while (!calc_done && cyc < 100) begin
      start = (poke && cyc == 1) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      cyc++;
      rnd = ra[(cyc + 1) % 128];
    end
    start = 1'b0;
    last_lat = cyc + 1;
    check({tag, "/latency"}, 128'(cyc), 128'(em));
    check({tag, "/done"}, 128'(calc_done), 128'(1));
    check({tag, "/busy_lo"}, 128'(busy), 128'(0));
    check({tag, "/board"}, 128'(cell_out), exp_board());
    check({tag, "/placed"}, 128'(placed), 128'(eplaced));
    check({tag, "/full"}, 128'(full), 128'(efull));
    @(posedge clk); #1;
    check({tag, "/pulse"}, 128'(calc_done), 128'(0));
    check({tag, "/hold"}, 128'(cell_out), exp_board());
  endtask

  task automatic fill_ra(input logic [RW-1:0] v);
    for (int k = 0; k < 128; k++) ra[k] = v;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; spawn_req = '0; cell_in = '0; order_in = '0; rnd = '0;
    start64 = 1'b0; spawn64 = '0; cell_in64 = '0; order64 = '0; rnd64 = '0;
    poke = 1'b0;
    #12;
    check("rst/board", 128'(cell_out), 128'(0));
    check("rst/flags", {busy, calc_done, full, placed}, 128'(0));
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < N; i++) od[i] = IW'(i);

    // Cells 13..15 empty, single spawn.
    for (int i = 0; i < N; i++) bd[i] = (i < 13) ? 5'd1 : 5'd0;
    fill_ra(6'b110000); sp = 2'd1;
    run("one");
    check("one/lat15", 128'(last_lat), 128'(15));
    check("one/c13", 128'(cell_out[13*CW +: CW]), 128'(1));

    sp = 2'd3;
    run("three");
    check("three/placed3", 128'(placed), 128'(3));

    for (int i = 0; i < N; i++) bd[i] = 5'd7;
    run("full");
    check("full/flag", 128'(full), 128'(1));

    // All empty, offset 5, tiles of value 2.
    for (int i = 0; i < N; i++) bd[i] = 5'd0;
    fill_ra(6'b000101); sp = 2'd2;
    run("four");
    check("four/c5c6", 128'({cell_out[5*CW +: CW], cell_out[6*CW +: CW]}), 128'({5'd2, 5'd2}));

    // Wrap-around from offset 14.
    for (int i = 0; i < N; i++) bd[i] = (i == 0 || i == 15) ? 5'd0 : 5'd3;
    fill_ra(6'b111110); sp = 2'd2;
    run("wrap");

    sp = 2'd0;
    run("zero");

    // Start pulsed while busy is ignored.
    for (int i = 0; i < N; i++) bd[i] = (i > 9) ? 5'd0 : 5'd4;
    fill_ra(6'b110000); sp = 2'd3; poke = 1'b1;
    run("poke");
    poke = 1'b0;

    // Reset mid-scan clears everything immediately.
    for (int i = 0; i < N; i++) bd[i] = 5'd6;
    @(negedge clk);
    start = 1'b1; spawn_req = 2'd3; rnd = 6'd0;
    for (int i = 0; i < N; i++) cell_in[i*CW +: CW] = bd[i];
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst = 1'b0; #1;
    check("midrst/board", 128'(cell_out), 128'(0));
    check("midrst/flags", {busy, calc_done, full, placed}, 128'(0));
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < N; i++) bd[i] = (i % 3 == 0) ? 5'd0 : 5'd2;
    fill_ra(6'b010011); sp = 2'd2;
    run("after_rst");

    // Randomized requests.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        bd[i] = ($urandom_range(0, 1) == 0) ? 5'd0 : CW'($urandom_range(1, 31));
        od[i] = (t % 2 == 0) ? IW'(i) : IW'($urandom_range(0, N - 1));
      end
      for (int k = 0; k < 128; k++) ra[k] = RW'($urandom);
      sp = SW'($urandom);
      run("rand");
    end

    // 64-cell instance, reversed order, only cell 0 empty, offset 63.
    @(negedge clk);
    for (int j = 0; j < 64; j++) begin
      cell_in64[j*6 +: 6] = (j == 0) ? 6'd0 : 6'd5;
      order64[j*6 +: 6]   = 6'(63 - j);
    end
    rnd64 = 6'd63; spawn64 = 2'd1; start64 = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0; rnd64 = 6'b111111;
    check("n64/busy", 128'(busy64), 128'(1));
    @(posedge clk); #1;
    check("n64/done", 128'(done64), 128'(1));
    check("n64/c0", 128'(cell_out64[5:0]), 128'(1));
    check("n64/rest", 128'(cell_out64[383:6] == cell_in64[383:6]), 128'(1));
    check("n64/placed", {full64, placed64}, 128'({1'b0, 2'd1}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
